alu_result_stage: RTL and testbench

// - Registered stage directly downstream of the 4-bit add/subtract datapath.
// - Captures each add/sub result (y, carryOut) with its operands and opcode, derives status flags
//   Z/N/C/V and buffers the results in a small FIFO.
// - Results leave on a valid/ready interface to the ALU output/writeback logic.
// - Also keeps the last accepted result, a sticky overflow flag and an operation counter.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_result_stage_if.sv | 30 +++
 rtl/alu_res_fifo.sv | 57 +++++
 rtl/alu_result_stage.sv | 84 ++++++++
 tb/tb_alu_result_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and width definitions for the ALU result path.
package alu_pkg;

  localparam int unsigned DATA_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_result_stage_if.sv
// Valid/ready buses between the add/sub datapath, the result stage and writeback.
interface alu_result_stage_if #(
  parameter int unsigned DATA_W = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [1:0]        in_opcode;
  logic [DATA_W-1:0] in_y;
  logic              in_carry;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic [3:0]        out_flags;
  logic [1:0]        out_opcode;

  modport master (
    output in_valid, in_a, in_b, in_opcode, in_y, in_carry, out_ready,
    input  in_ready, out_valid, out_y, out_flags, out_opcode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, in_y, in_carry, out_ready,
    output in_ready, out_valid, out_y, out_flags, out_opcode
  );

endinterface

// File: rtl/alu_res_fifo.sv
// Small synchronous FIFO; the head entry is read straight from the storage registers.
module alu_res_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses the push even if the head leaves in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage after the add/sub datapath: flags, result FIFO, accumulator,
// sticky overflow and saturating op counter.
module alu_result_stage #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus,
  output logic [DATA_W-1:0]   acc,
  output logic                ovf_sticky,
  input  logic                clr_sticky,
  output logic [CNT_W-1:0]    op_count
);

  import alu_pkg::*;

  localparam int unsigned PW = DATA_W + 6;
  localparam int unsigned MSB = DATA_W - 1;

  logic                   accept;
  logic [3:0]             flags;
  logic [PW-1:0]          fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   b_msb;
  logic                   status_unused;

  assign bus.in_ready = (fifo_count < ($clog2(DEPTH)+1)'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;

  // Overflow compares against b as the adder saw it (inverted for subtract).
  always_comb begin
    flags         = '0;
    b_msb         = bus.in_b[MSB] ^ bus.in_opcode[0];
    flags[FLAG_Z] = (bus.in_y == '0);
    flags[FLAG_N] = bus.in_y[MSB];
    flags[FLAG_C] = bus.in_carry;
    flags[FLAG_V] = (bus.in_a[MSB] == b_msb) && (bus.in_y[MSB] != bus.in_a[MSB]);
  end

  assign status_unused = ^{fifo_full, bus.in_a, bus.in_b};

  alu_res_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   ({bus.in_y, flags, bus.in_opcode}),
    .pop   (bus.out_ready),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign {bus.out_y, bus.out_flags, bus.out_opcode} = fifo_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      op_count   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (accept) begin
        acc <= bus.in_y;
        if (op_count != '1) begin
          op_count <= op_count + CNT_W'(1);
        end
      end
      if (accept && flags[FLAG_V]) begin
        ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; inputs change and outputs are sampled on the falling edge.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_sticky;
  logic [3:0] acc;
  logic       ovf_sticky;
  logic [7:0] op_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  alu_result_stage_if #(.DATA_W(4)) bus ();

  alu_result_stage #(
    .DATA_W (4),
    .DEPTH  (2),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .acc        (acc),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic [3:0] y, input logic c);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_opcode = op;
    bus.in_y      = y;
    bus.in_carry  = c;
  endtask

  task automatic push_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         input logic [3:0] y, input logic c);
    drive(a, b, op, y, c);
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  logic [3:0] ta, tb, ty, last_y, prev_y;
  logic       tc;
  int         sum;

  initial begin
    rst_n         = 1'b0;
    clr_sticky    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_opcode = '0;
    bus.in_y      = '0;
    bus.in_carry  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;

    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready",  32'(bus.in_ready), 1);
    check("rst_out_y",     32'(bus.out_y), 0);
    check("rst_out_flags", 32'(bus.out_flags), 0);
    check("rst_acc",       32'(acc), 0);
    check("rst_op_count",  32'(op_count), 0);
    check("rst_ovf",       32'(ovf_sticky), 0);

    // 7+9 = 0 carry 1
    push_op(4'd7, 4'd9, 2'b00, 4'd0, 1'b1);
    check("add0_valid", 32'(bus.out_valid), 1);
    check("add0_y",     32'(bus.out_y), 0);
    check("add0_flags", 32'(bus.out_flags), 32'b1010);
    check("add0_cnt",   32'(op_count), 1);
    pop_one();
    check("add0_drained", 32'(bus.out_valid), 0);

    // 7+1 = 8 signed overflow
    push_op(4'd7, 4'd1, 2'b00, 4'd8, 1'b0);
    check("add8_y",     32'(bus.out_y), 8);
    check("add8_flags", 32'(bus.out_flags), 32'b0101);
    check("add8_ovf",   32'(ovf_sticky), 1);
    check("add8_acc",   32'(acc), 8);
    clr_sticky = 1'b1;
    pop_one();
    clr_sticky = 1'b0;
    check("clr_ovf", 32'(ovf_sticky), 0);

    // X on idle inputs must not reach any register
    bus.in_a = 'x; bus.in_b = 'x; bus.in_y = 'x; bus.in_opcode = 'x; bus.in_carry = 1'bx;
    cycle();
    check("idle_acc",   32'(acc), 8);
    check("idle_cnt",   32'(op_count), 2);
    check("idle_valid", 32'(bus.out_valid), 0);

    // 3-5 = 14 borrow
    push_op(4'd3, 4'd5, 2'b01, 4'd14, 1'b0);
    check("sub35_y",     32'(bus.out_y), 14);
    check("sub35_flags", 32'(bus.out_flags), 32'b0100);
    check("sub35_op",    32'(bus.out_opcode), 1);
    pop_one();
    // 5-5 = 0 no borrow
    push_op(4'd5, 4'd5, 2'b01, 4'd0, 1'b1);
    check("sub55_flags", 32'(bus.out_flags), 32'b1010);
    check("sub55_ovf",   32'(ovf_sticky), 0);
    pop_one();

    // Overflow set and clear in the same cycle: set wins; opcode[1] only stored
    clr_sticky = 1'b1;
    push_op(4'd7, 4'd1, 2'b10, 4'd8, 1'b0);
    clr_sticky = 1'b0;
    check("setwin_ovf",   32'(ovf_sticky), 1);
    check("op2_flags",    32'(bus.out_flags), 32'b0101);
    check("op2_opcode",   32'(bus.out_opcode), 2);
    clr_sticky = 1'b1;
    pop_one();
    clr_sticky = 1'b0;
    check("clr2_ovf", 32'(ovf_sticky), 0);

    // Back-pressure: two fill the FIFO, third stalls until the first pop
    drive(4'd1, 4'd1, 2'b00, 4'd2, 1'b0);
    check("bp_rdy0", 32'(bus.in_ready), 1);
    cycle();
    drive(4'd2, 4'd2, 2'b00, 4'd4, 1'b0);
    check("bp_rdy1", 32'(bus.in_ready), 1);
    cycle();
    drive(4'd3, 4'd3, 2'b00, 4'd6, 1'b0);
    check("bp_full", 32'(bus.in_ready), 0);
    check("bp_cnt2", 32'(op_count), 7);
    cycle();
    check("bp_stall_rdy", 32'(bus.in_ready), 0);
    check("bp_head_hold", 32'(bus.out_y), 2);
    check("bp_cnt_hold",  32'(op_count), 7);
    bus.out_ready = 1'b1;
    cycle();
    check("bp_pop1_y",   32'(bus.out_y), 4);
    check("bp_pop1_rdy", 32'(bus.in_ready), 1);
    check("bp_pop1_cnt", 32'(op_count), 7);
    cycle();
    bus.in_valid = 1'b0;
    check("bp_third_y",   32'(bus.out_y), 6);
    check("bp_third_cnt", 32'(op_count), 8);
    check("bp_acc",       32'(acc), 6);
    cycle();
    check("bp_empty", 32'(bus.out_valid), 0);

    // Sustained streaming, one op per cycle
    prev_y = '0;
    for (int i = 0; i < 300; i++) begin
      ta  = 4'(i);
      tb  = 4'(i * 3 + 1);
      sum = int'(ta) + int'(tb);
      ty  = 4'(sum);
      tc  = (sum > 15);
      drive(ta, tb, 2'b00, ty, tc);
      if (i > 0) begin
        check("str_valid", 32'(bus.out_valid), 1);
        check("str_rdy",   32'(bus.in_ready), 1);
        check("str_y",     32'(bus.out_y), 32'(prev_y));
      end
      prev_y = ty;
      cycle();
    end
    last_y = prev_y;
    bus.in_valid = 1'b0;
    check("str_last_y", 32'(bus.out_y), 32'(last_y));
    check("str_sat",    32'(op_count), 255);
    check("str_acc",    32'(acc), 32'(last_y));
    cycle();
    bus.out_ready = 1'b0;
    check("str_empty", 32'(bus.out_valid), 0);

    // Reset with two buffered entries and a push offered
    push_op(4'd7, 4'd1, 2'b00, 4'd8, 1'b0);
    push_op(4'd4, 4'd4, 2'b00, 4'd8, 1'b0);
    check("pre_rst_full", 32'(bus.in_ready), 0);
    check("pre_rst_ovf",  32'(ovf_sticky), 1);
    drive(4'd1, 4'd2, 2'b00, 4'd3, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("mrst_valid", 32'(bus.out_valid), 0);
    check("mrst_rdy",   32'(bus.in_ready), 1);
    check("mrst_acc",   32'(acc), 0);
    check("mrst_cnt",   32'(op_count), 0);
    check("mrst_ovf",   32'(ovf_sticky), 0);
    check("mrst_y",     32'(bus.out_y), 0);
    cycle();
    check("mrst_still_empty", 32'(bus.out_valid), 0);

    push_op(4'd1, 4'd2, 2'b00, 4'd3, 1'b0);
    check("post_rst_y",     32'(bus.out_y), 3);
    check("post_rst_flags", 32'(bus.out_flags), 0);
    check("post_rst_cnt",   32'(op_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
